// File: rtl/attitude_pkg.sv
// Shared definitions for the attitude indicator: code bit positions, the
// level code, LED grid indices and the decoder FSM state encoding.
package attitude_pkg;

  // Bit positions inside the 4-bit encoder code
  localparam int ROLL_SGN  = 3;
  localparam int PITCH_SGN = 2;
  localparam int ROLL_LVL  = 1;
  localparam int PITCH_LVL = 0;

  // Both axes level
  localparam logic [3:0] LEVEL_CODE = 4'b0011;

  // LED grid, index = row*3 + col; rows up/level/down, cols left/level/right
  localparam int LED_COUNT      = 9;
  localparam int LED_UP_LEFT    = 0;
  localparam int LED_UP         = 1;
  localparam int LED_UP_RIGHT   = 2;
  localparam int LED_LEFT       = 3;
  localparam int LED_LEVEL      = 4;
  localparam int LED_RIGHT      = 5;
  localparam int LED_DOWN_LEFT  = 6;
  localparam int LED_DOWN       = 7;
  localparam int LED_DOWN_RIGHT = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_STALE = 2'd2
  } state_t;

  // A level axis has no meaningful sign, so its sign bit is cleared.
  function automatic logic [3:0] canonicalize(input logic [3:0] code);
    logic [3:0] c;
    c = code;
    if (code[ROLL_LVL])  c[ROLL_SGN]  = 1'b0;
    if (code[PITCH_LVL]) c[PITCH_SGN] = 1'b0;
    return c;
  endfunction

  // One-hot LED addressed by a code.
  function automatic logic [LED_COUNT-1:0] led_onehot(input logic [3:0] code);
    logic [1:0] row;
    logic [1:0] col;
    logic [3:0] idx;
    col = code[ROLL_LVL]  ? 2'd1 : (code[ROLL_SGN]  ? 2'd0 : 2'd2);
    row = code[PITCH_LVL] ? 2'd1 : (code[PITCH_SGN] ? 2'd2 : 2'd0);
    idx = {2'b00, row} * 4'd3 + {2'b00, col};
    return LED_COUNT'(1) << idx;
  endfunction

endpackage

// File: rtl/attitude_blink_gen.sv
// Blink phase generator: a prescaler that toggles the phase every
// HALF_PERIOD clocks. A restart puts the phase at 1 with a fresh count.
module attitude_blink_gen #(
  parameter int HALF_PERIOD = 6_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase
);

  localparam int              W    = $clog2(HALF_PERIOD + 1);
  localparam logic [W-1:0]    LAST = W'(HALF_PERIOD - 1);

  logic [W-1:0] presc;

  // Prescaler wrap toggles the phase; restart wins over counting
  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc <= '0;
      phase <= 1'b1;
    end else if (restart) begin
      presc <= '0;
      phase <= 1'b1;
    end else if (presc == LAST) begin
      presc <= '0;
      phase <= ~phase;
    end else begin
      presc <= presc + W'(1);
    end
  end

endmodule

// File: rtl/attitude_decoder.sv
// Attitude decoder: canonicalizes and debounces the encoder code, then
// drives a 3x3 indicator grid that blinks whenever the aircraft is not level.
// Optional stale-input detection is built when ATTITUDE_DECODER_STALE_EN is
// defined; otherwise o_Stale is tied low and the FSM uses IDLE/TRACK only.
module attitude_decoder #(
  parameter int STABLE_COUNT      = 4,
  parameter int BLINK_HALF_PERIOD = 6_000_000,
  parameter int TIMEOUT_CYCLES    = 1_200_000
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Sample_Valid,
  input  logic [3:0] i_Attitude,
  output logic [3:0] o_Attitude,
  output logic       o_Valid,
  output logic [8:0] o_LED,
  output logic       o_Stale
);

  import attitude_pkg::*;

  localparam int              CW      = $clog2(STABLE_COUNT + 1);
  localparam logic [CW-1:0]   CNT_MAX = CW'(STABLE_COUNT);

  logic [3:0]    sample;
  logic [3:0]    cand;
  logic [3:0]    cand_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          commit;
  logic          phase;
  logic          timeout;
  state_t        state;

  assign sample = canonicalize(i_Attitude);

  // Next candidate/count and the commit decision for the current strobe
  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (i_Sample_Valid) begin
      if (sample == cand) begin
        if (cnt != CNT_MAX) cnt_next = cnt + CW'(1);
      end else begin
        cand_next = sample;
        cnt_next  = CW'(1);
      end
    end
    commit = i_Sample_Valid && (cnt_next == CNT_MAX) && (cand_next != o_Attitude);
  end

  // Filter state and the committed code
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      cand       <= LEVEL_CODE;
      cnt        <= '0;
      o_Attitude <= LEVEL_CODE;
      o_Valid    <= 1'b0;
    end else begin
      cand <= cand_next;
      cnt  <= cnt_next;
      if (commit) begin
        o_Attitude <= cand_next;
        o_Valid    <= 1'b1;
      end
    end
  end

  attitude_blink_gen #(
    .HALF_PERIOD (BLINK_HALF_PERIOD)
  ) u_blink (
    .clk     (i_Clk),
    .rst     (i_Rst),
    .restart (commit),
    .phase   (phase)
  );

`ifdef ATTITUDE_DECODER_STALE_EN
  localparam int              TW     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_MAX = TW'(TIMEOUT_CYCLES);

  logic [TW-1:0] quiet_cnt;
  logic [TW-1:0] quiet_next;

  // Strobe-free clock count, saturating at the timeout
  always_comb begin
    quiet_next = '0;
    if (!i_Sample_Valid)
      quiet_next = (quiet_cnt == TO_MAX) ? quiet_cnt : quiet_cnt + TW'(1);
    timeout = !i_Sample_Valid && (quiet_next == TO_MAX);
  end

  // Timeout counter register
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) quiet_cnt <= '0;
    else       quiet_cnt <= quiet_next;
  end
`else
  // The timeout length has no meaning without stale detection
  logic unused_timeout;
  assign unused_timeout = |TIMEOUT_CYCLES;
  assign timeout        = 1'b0;
`endif

  // Display FSM with registered LED and stale outputs
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state   <= ST_IDLE;
      o_LED   <= '0;
      o_Stale <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (commit) begin
            state <= ST_TRACK;
          end else if (timeout) begin
            state   <= ST_STALE;
            o_Stale <= 1'b1;
          end
          o_LED <= '0;
        end
`ifdef ATTITUDE_DECODER_STALE_EN
        ST_STALE: begin
          if (i_Sample_Valid) begin
            state   <= ST_TRACK;
            o_Stale <= 1'b0;
          end
          o_LED <= {LED_COUNT{phase}};
        end
`endif
        ST_TRACK: begin
          if (timeout) begin
            state   <= ST_STALE;
            o_Stale <= 1'b1;
          end
          if (o_Attitude == LEVEL_CODE) o_LED <= LED_COUNT'(1) << LED_LEVEL;
          else if (phase)               o_LED <= led_onehot(o_Attitude);
          else                          o_LED <= '0;
        end
        default: begin
          state   <= ST_IDLE;
          o_LED   <= '0;
          o_Stale <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/attitude_decoder.md
# attitude_decoder

- Decodes the 4-bit attitude code `[sgn(roll), sgn(pitch), isZero(roll), isZero(pitch)]` from the roll/pitch encoder into a 3x3 indicator LED grid.
- Sits between the encoder and the board LEDs.
- Filters the incoming code so that it must be stable for a programmable number of samples before it is shown.
- Blinks the indicator whenever the aircraft is not level, and optionally flags a stale input when samples stop arriving.

## Interface
Parameters:
- `STABLE_COUNT`, 4: consecutive matching samples required to commit a code (1 to 15).
- `BLINK_HALF_PERIOD`, 6_000_000: clocks per blink half-period.
- `TIMEOUT_CYCLES`, 1_200_000: clocks without a sample before the input is declared stale.

Ports:
- `i_Clk` in 1: system clock. Single clock domain; reset is asynchronous and active-high.
- `i_Rst` in 1: asynchronous, active-high reset.
- `i_Sample_Valid` in 1: one-cycle strobe; `i_Attitude` is sampled when it is high.
- `i_Attitude` in 4: encoder code. Bit 3 is roll sign (1 = negative/left), bit 2 is pitch sign (1 = negative/down), bit 1 is roll level, bit 0 is pitch level.
- `o_Attitude` out 4: committed, canonicalized code.
- `o_Valid` out 1: high once any code has been committed since reset.
- `o_LED` out 9: one-hot grid, index = row*3 + col. Row 0/1/2 = up/level/down; col 0/1/2 = left/level/right.
- `o_Stale` out 1: input timeout flag. Tied to 0 when the stale feature is compiled out.

## Operation
Canonicalization:
- If bit 1 is set, bit 3 is forced to 0. If bit 0 is set, bit 2 is forced to 0.
- Sign noise near zero therefore never disturbs the filter.

Filter (on each `i_Sample_Valid`, using the canonical sample):
- Sample equals the candidate: the count increments, saturating at `STABLE_COUNT`.
- Sample differs from the candidate: the candidate takes the sample and the count is set to 1.
- When the count reaches `STABLE_COUNT` and the candidate differs from `o_Attitude`, `o_Attitude` takes the candidate and `o_Valid` is set.
- A candidate equal to the committed code causes no commit event.
- `STABLE_COUNT = 1` commits on the first sample.

LED decode:
- col = 1 if roll level, else 0 if roll sign = 1, else 2.
- row = 1 if pitch level, else 2 if pitch sign = 1, else 0.
- Exactly one LED is addressed.
- Code 4'b0011 (both level): LED 4 is lit steady.
- Any other code: the addressed LED is lit only while blink phase = 1.

Blink generator:
- The prescaler counts 0 to `BLINK_HALF_PERIOD`-1 and toggles the phase on wrap.
- A commit event restarts the prescaler with phase = 1, so a new code is always shown immediately.

FSM states:
- IDLE: after reset, no commit yet. `o_LED` = 0. Goes to TRACK on the first commit.
- TRACK: normal decode. Goes to STALE when the timeout counter reaches `TIMEOUT_CYCLES`.
- STALE: `o_Stale` = 1 and all nine LEDs follow the blink phase. The next `i_Sample_Valid` returns to TRACK on that edge. The committed code and the filter state are preserved.

Timeout counter:
- Clears on every `i_Sample_Valid` and increments otherwise.
- Counts in IDLE too, so a dead input after reset reaches STALE.
- In IDLE, STALE is entered even with `o_Valid` = 0.

## Timing
Reset values:
- `o_Attitude` = 4'b0011, `o_Valid` = 0, `o_LED` = 0, `o_Stale` = 0.
- Candidate = 4'b0011, count = 0, blink phase = 1, state = IDLE.

Latency:
- `o_Attitude` and `o_Valid` update on the edge that captures the `STABLE_COUNT`-th matching sample.
- `o_LED` is registered and updates one edge later.

Other timing rules:
- `o_Stale` rises on the edge on which the counter equals `TIMEOUT_CYCLES`, and falls on the edge that captures the next valid sample.
- A sample strobe arriving on the timeout edge wins: no STALE entry.
- Reset mid-filter or mid-blink returns everything to the reset values within the reset assertion; nothing is held over.
- Counter widths are $clog2(param+1). All counters are unsigned and saturate or wrap as stated, never overflow.

## Configuration
`ATTITUDE_DECODER_STALE_EN`:
- Defined: the timeout counter and the STALE state exist as described.
- Undefined: no timeout logic, `o_Stale` is a constant 0, and the FSM is IDLE/TRACK only.

## Structure
- Package `attitude_pkg` holds:
  - the code bit index constants (ROLL_SGN=3, PITCH_SGN=2, ROLL_LVL=1, PITCH_LVL=0);
  - the LEVEL_CODE 4'b0011;
  - the LED index constants;
  - the FSM state encoding.
- One sub-module, `attitude_blink_gen`, is natural: prescaler plus phase, with a restart input and a phase output.

## Test plan
- Reset, then four valid samples of 4'b0000 -> `o_Attitude` = 0000 on the 4th sample edge; `o_LED` = 9'b000000100 (up-right) one edge later, blinking.
- Samples 0011, 1011, 0011, 1011 (sign noise while level) -> canonicalized to 0011; one commit after the 4th sample; LED 4 lit steady.
- Three samples of 1000, then one of 0100 -> no commit; candidate becomes 0100 with count 1; `o_Attitude` unchanged.
- Commit 1000 (up-left) mid-phase-0 -> phase restarts at 1; LED 0 lit on the next edge; toggles after `BLINK_HALF_PERIOD` clocks.
- With the macro defined, stop strobes for `TIMEOUT_CYCLES` -> `o_Stale` = 1 and all nine LEDs blink. One strobe -> `o_Stale` = 0 on that edge and the prior code is redisplayed.
- Assert `i_Rst` asynchronously between two matching samples -> all outputs return to reset values immediately; four fresh samples are then needed to commit.
